// File: rtl/robot_sensor_responder_pkg.sv
// Constants shared by world and robot: map size, orientations and map cell codes.
package robot_sensor_responder_pkg;

  localparam int MAP_ROWS   = 10;
  localparam int MAP_COLS   = 20;
  localparam int MAP_ADDR_W = 8;

  typedef enum logic [2:0] {
    NORTH = 3'd0,
    SOUTH = 3'd1,
    EAST  = 3'd2,
    WEST  = 3'd3
  } orient_e;

  typedef enum logic [1:0] {
    FREE     = 2'd0,
    WALL     = 2'd1,
    TRASH    = 2'd2,
    RESERVED = 2'd3
  } cell_e;

endpackage

// File: rtl/robot_neighbour_calc.sv
// Combinational map of (row, col, orientation) to the ROM addresses of the cells
// ahead and to the left, flagging neighbours outside the map and illegal positions.
module robot_neighbour_calc
  import robot_sensor_responder_pkg::*;
#(
  parameter int ROWS   = MAP_ROWS,
  parameter int COLS   = MAP_COLS,
  parameter int ADDR_W = MAP_ADDR_W
) (
  input  logic [5:0]        row,
  input  logic [5:0]        col,
  input  logic [2:0]        orient,
  output logic [ADDR_W-1:0] ahead_addr,
  output logic              ahead_out,
  output logic [ADDR_W-1:0] left_addr,
  output logic              left_out,
  output logic              illegal
);

  typedef logic signed [6:0] coord_t;

  localparam coord_t ONE     = 7'sd1;
  localparam coord_t ROW_MAX = coord_t'(ROWS);
  localparam coord_t COL_MAX = coord_t'(COLS);

  function automatic logic off_map(input coord_t r, input coord_t c);
    return (r < ONE) || (r > ROW_MAX) || (c < ONE) || (c > COL_MAX);
  endfunction

  function automatic logic [ADDR_W-1:0] cell_addr(input coord_t r, input coord_t c);
    int a;
    a = (int'(r) - 1) * COLS + (int'(c) - 1);
    return a[ADDR_W-1:0];
  endfunction

  coord_t r, c, ar, ac, lr, lc;

  // NOTE: every variable is given a value before the case, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    r  = signed'({1'b0, row});
    c  = signed'({1'b0, col});
    ar = r;
    ac = c;
    lr = r;
    lc = c;
    case (orient)
      NORTH:   begin ar = r - ONE; lc = c - ONE; end
      SOUTH:   begin ar = r + ONE; lc = c + ONE; end
      EAST:    begin ac = c + ONE; lr = r - ONE; end
      WEST:    begin ac = c - ONE; lr = r + ONE; end
      default: ;
    endcase
    // An illegal request forces both neighbours blocked, which also hides any wrapped arithmetic.
    illegal    = off_map(r, c) || (orient > 3'd3);
    ahead_out  = illegal || off_map(ar, ac);
    left_out   = illegal || off_map(lr, lc);
    ahead_addr = ahead_out ? '0 : cell_addr(ar, ac);
    left_addr  = left_out  ? '0 : cell_addr(lr, lc);
  end

endmodule

// File: rtl/robot_sensor_responder.sv
// World-side sensor responder: latches the robot pose on req, reads the cells ahead
// and to the left from the sync map ROM, and returns blocked/trash bits with a valid strobe.
module robot_sensor_responder
  import robot_sensor_responder_pkg::*;
#(
  parameter int ROWS   = MAP_ROWS,
  parameter int COLS   = MAP_COLS,
  parameter int ADDR_W = MAP_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic [5:0]        robot_row,
  input  logic [5:0]        robot_column,
  input  logic [2:0]        robot_orientation,
  output logic [ADDR_W-1:0] map_addr,
  input  logic [1:0]        map_data,
  output logic              head,
  output logic              left,
  output logic              head_trash,
  output logic              busy,
  output logic              valid,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_HEAD,
    S_RD_LEFT,
    S_CAP_LEFT,
    S_DONE
  } state_e;

  state_e            state;
  logic [5:0]        lat_row, lat_col;
  logic [2:0]        lat_orient;
  logic [5:0]        calc_row, calc_col;
  logic [2:0]        calc_orient;
  logic [ADDR_W-1:0] ahead_addr, left_addr;
  logic              ahead_out, left_out, illegal;
  cell_e             ahead_code, left_code;

  // In IDLE the live inputs feed the calculator so the ahead address is ready at the accepting edge.
  always_comb begin
    calc_row    = lat_row;
    calc_col    = lat_col;
    calc_orient = lat_orient;
    if (state == S_IDLE) begin
      calc_row    = robot_row;
      calc_col    = robot_column;
      calc_orient = robot_orientation;
    end
  end

  robot_neighbour_calc #(
    .ROWS   (ROWS),
    .COLS   (COLS),
    .ADDR_W (ADDR_W)
  ) u_neighbour_calc (
    .row        (calc_row),
    .col        (calc_col),
    .orient     (calc_orient),
    .ahead_addr (ahead_addr),
    .ahead_out  (ahead_out),
    .left_addr  (left_addr),
    .left_out   (left_out),
    .illegal    (illegal)
  );

  // NOTE: non-blocking assignments throughout, so every register here sees pre-edge values of the others.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= S_IDLE;
      lat_row    <= '0;
      lat_col    <= '0;
      lat_orient <= '0;
      ahead_code <= FREE;
      left_code  <= FREE;
      map_addr   <= '0;
      head       <= 1'b0;
      left       <= 1'b0;
      head_trash <= 1'b0;
      busy       <= 1'b0;
      valid      <= 1'b0;
      error      <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            lat_row    <= robot_row;
            lat_col    <= robot_column;
            lat_orient <= robot_orientation;
            map_addr   <= ahead_addr;
            busy       <= 1'b1;
            state      <= S_RD_HEAD;
          end
        end
        S_RD_HEAD: begin
          map_addr <= left_addr;
          state    <= S_RD_LEFT;
        end
        S_RD_LEFT: begin
          ahead_code <= cell_e'(map_data);
          map_addr   <= '0;
          state      <= S_CAP_LEFT;
        end
        S_CAP_LEFT: begin
          left_code <= cell_e'(map_data);
          state     <= S_DONE;
        end
        S_DONE: begin
          head       <= ahead_out || (ahead_code != FREE);
          left       <= left_out || (left_code != FREE);
          head_trash <= !ahead_out && (ahead_code == TRASH);
          error      <= illegal;
          valid      <= 1'b1;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_robot_sensor_responder.sv
// Bench for robot_sensor_responder: sync ROM model, pose-level reference model with a
// per-cycle compare process, directed cases with literal expectations, then random traffic.
module tb_robot_sensor_responder;
  import robot_sensor_responder_pkg::*;

  localparam int ROWS   = MAP_ROWS;
  localparam int COLS   = MAP_COLS;
  localparam int ADDR_W = MAP_ADDR_W;
  localparam int CELLS  = ROWS * COLS;

  // Offsets indexed by orientation N, S, E, W.
  localparam int AHEAD_DR[4] = '{-1, 1, 0, 0};
  localparam int AHEAD_DC[4] = '{0, 0, 1, -1};
  localparam int LEFT_DR[4]  = '{0, 0, -1, 1};
  localparam int LEFT_DC[4]  = '{-1, 1, 0, 0};

  logic              clock = 1'b0;
  logic              reset;
  logic              req;
  logic [5:0]        robot_row, robot_column;
  logic [2:0]        robot_orientation;
  logic [ADDR_W-1:0] map_addr;
  logic [1:0]        map_data = 2'd0;
  logic              head, left, head_trash, busy, valid, error;

  robot_sensor_responder #(.ROWS(ROWS), .COLS(COLS), .ADDR_W(ADDR_W)) dut (
    .clock             (clock),
    .reset             (reset),
    .req               (req),
    .robot_row         (robot_row),
    .robot_column      (robot_column),
    .robot_orientation (robot_orientation),
    .map_addr          (map_addr),
    .map_data          (map_data),
    .head              (head),
    .left              (left),
    .head_trash        (head_trash),
    .busy              (busy),
    .valid             (valid),
    .error             (error)
  );

  always #5 clock = ~clock;

  logic [1:0] rom [CELLS];
  always @(posedge clock) map_data <= (int'(map_addr) < CELLS) ? rom[map_addr] : 2'd0;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic h, l, ht, er;
    int   aa, la;
  } result_t;

  function automatic void probe(input int r, input int c, output logic blk,
                                output logic trash, output int addr);
    if (r < 1 || r > ROWS || c < 1 || c > COLS) begin
      blk = 1'b1; trash = 1'b0; addr = 0;
    end else begin
      addr  = (r - 1) * COLS + (c - 1);
      blk   = (rom[addr] != 2'd0);
      trash = (rom[addr] == 2'd2);
    end
  endfunction

  function automatic result_t model_lookup(input int r, input int c, input int o);
    result_t res;
    logic    unused_trash;
    res = '{h: 1'b1, l: 1'b1, ht: 1'b0, er: 1'b1, aa: 0, la: 0};
    if (r < 1 || r > ROWS || c < 1 || c > COLS || o > 3) return res;
    res.er = 1'b0;
    probe(r + AHEAD_DR[o], c + AHEAD_DC[o], res.h, res.ht, res.aa);
    probe(r + LEFT_DR[o], c + LEFT_DC[o], res.l, unused_trash, res.la);
    return res;
  endfunction

  // Reference timing: an accepted request produces its valid 4 edges later; requests
  // arriving while a lookup is outstanding (including the completing edge) are dropped.
  int      m_cnt = 0;
  logic    m_valid = 1'b0;
  result_t m_pend, m_exp;

  always @(posedge clock) begin
    if (!reset) begin
      m_cnt   = 0;
      m_valid = 1'b0;
      m_exp   = '{h: 1'b0, l: 1'b0, ht: 1'b0, er: 1'b0, aa: 0, la: 0};
    end else begin
      m_valid = 1'b0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_valid = 1'b1;
          m_exp   = m_pend;
        end
      end else if (req) begin
        m_pend = model_lookup(int'(robot_row), int'(robot_column), int'(robot_orientation));
        m_cnt  = 4;
      end
    end
  end

  bit   chk_en     = 1'b0;
  logic prev_valid = 1'b0;

  always @(negedge clock) begin
    if (chk_en) begin
      check("valid", 32'(valid), 32'(m_valid));
      check("valid_back_to_back", 32'(prev_valid & valid), 32'd0);
      check("busy", 32'(busy), 32'(m_cnt != 0));
      check("head", 32'(head), 32'(m_exp.h));
      check("left", 32'(left), 32'(m_exp.l));
      check("head_trash", 32'(head_trash), 32'(m_exp.ht));
      check("error", 32'(error), 32'(m_exp.er));
      if (m_cnt == 4) check("map_addr_ahead", 32'(map_addr), m_pend.aa);
      if (m_cnt == 3) check("map_addr_left", 32'(map_addr), m_pend.la);
      prev_valid = valid;
    end
  end

  task automatic set_cell(input int r, input int c, input cell_e code);
    rom[(r - 1) * COLS + (c - 1)] = code;
  endtask

  // Issues one request, scrambles the inputs after sampling, and returns the two
  // read addresses; leaves the caller on the cycle where valid is expected.
  task automatic run_req(input int r, input int c, input int o, output int addr0, output int addr1);
    int lat;
    @(negedge clock);
    req = 1'b1;
    robot_row = 6'(r);
    robot_column = 6'(c);
    robot_orientation = 3'(o);
    @(negedge clock);
    req = 1'b0;
    addr0 = int'(map_addr);
    robot_row = 6'($urandom);
    robot_column = 6'($urandom);
    robot_orientation = 3'($urandom);
    @(negedge clock);
    addr1 = int'(map_addr);
    lat = 1;
    while (!valid && lat < 12) begin
      @(negedge clock);
      lat++;
    end
    check("latency", lat, 4);
  endtask

  int a0, a1, nv;

  initial begin
    reset = 1'b0;
    req = 1'b0;
    robot_row = '0;
    robot_column = '0;
    robot_orientation = '0;
    for (int i = 0; i < CELLS; i++) rom[i] = FREE;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk_en = 1'b1;
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_head_left", 32'({head, left, head_trash, error}), 32'd0);
    check("rst_map_addr", 32'(map_addr), 32'd0);
    reset = 1'b1;

    // (5,10) facing north on an all-free map: ahead (4,10), left (5,9).
    run_req(5, 10, int'(NORTH), a0, a1);
    check("t1_addr_ahead", a0, 69);
    check("t1_addr_left", a1, 88);
    check("t1_sensors", 32'({valid, head, left, head_trash, error}), 32'b10000);

    run_req(1, 1, int'(NORTH), a0, a1);
    check("t2a_sensors", 32'({head, left, head_trash, error}), 32'b1100);
    set_cell(2, 1, WALL);
    set_cell(1, 2, WALL);
    run_req(1, 1, int'(SOUTH), a0, a1);
    check("t2b_sensors", 32'({head, left, head_trash, error}), 32'b1100);
    set_cell(2, 1, FREE);
    set_cell(1, 2, FREE);

    set_cell(5, 11, TRASH);
    run_req(5, 10, int'(EAST), a0, a1);
    check("t3_sensors", 32'({head, left, head_trash, error}), 32'b1010);

    run_req(0, 3, int'(NORTH), a0, a1);
    check("t4_row0", 32'({head, left, head_trash, error}), 32'b1101);
    run_req(4, 21, int'(WEST), a0, a1);
    check("t4_col21", 32'({head, left, head_trash, error}), 32'b1101);
    run_req(4, 4, 5, a0, a1);
    check("t4_orient5", 32'({head, left, head_trash, error}), 32'b1101);
    run_req(5, 10, int'(NORTH), a0, a1);
    check("t4_error_cleared", 32'({head, left, head_trash, error}), 32'b0000);

    // req held high for 12 cycles: accepted only every 5th edge.
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (valid) nv++;
      req = (i < 12);
      robot_row = 6'($urandom_range(1, ROWS));
      robot_column = 6'($urandom_range(1, COLS));
      robot_orientation = 3'($urandom_range(0, 3));
    end
    req = 1'b0;
    check("t5_valid_count", nv, 3);

    // Reset asserted while the left cell is being read aborts the lookup.
    @(negedge clock);
    req = 1'b1;
    robot_row = 6'd5;
    robot_column = 6'd10;
    robot_orientation = 3'(NORTH);
    @(negedge clock);
    req = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("t6_outputs_zero", 32'({valid, busy, head, left, head_trash, error}), 32'd0);
    check("t6_map_addr_zero", 32'(map_addr), 32'd0);
    reset = 1'b1;
    nv = 0;
    repeat (6) begin
      @(negedge clock);
      if (valid) nv++;
    end
    check("t6_no_valid", nv, 0);
    run_req(3, 3, int'(WEST), a0, a1);
    check("t6_fresh_req", 32'({valid, head, left, head_trash, error}), 32'b10000);

    // Random map and random traffic, checked cycle by cycle against the model.
    for (int i = 0; i < CELLS; i++) rom[i] = 2'($urandom);
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      req = ($urandom_range(0, 2) == 0);
      robot_row = 6'($urandom_range(0, ROWS + 1));
      robot_column = 6'($urandom_range(0, COLS + 1));
      robot_orientation = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7))
                                                      : 3'($urandom_range(0, 3));
    end
    req = 1'b0;
    repeat (8) @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
